// File: rtl/dmem_port.sv
// dmem_port: handshaked data-memory port for the MEM stage.
// One request in flight; each accepted request yields exactly one response.
// Loads: programmable read latency RD_LAT. Stores and errors: respond one cycle after acceptance.
// Optional feature macro: DMEM_BYTE_LANE_EN.
//   Defined:   byte and halfword accesses, with lane select and sign/zero extension.
//   Undefined: word-only port; any other size is reported as an error.
module dmem_port #(
    parameter int WORD_BYTES  = 4,
    parameter int DEPTH_WORDS = 1024,
    parameter int RD_LAT      = 2,
    parameter int ADDR_W      = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_we,
    input  logic [1:0]              req_size,
    input  logic                    req_signed,
    input  logic [ADDR_W-1:0]       req_addr,
    input  logic [8*WORD_BYTES-1:0] req_wdata,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [8*WORD_BYTES-1:0] rsp_rdata,
    output logic                    rsp_err
);
    localparam int DATA_W = 8 * WORD_BYTES;
    localparam int LANE_W = $clog2(WORD_BYTES);
    localparam int IDX_W  = $clog2(DEPTH_WORDS);
    localparam int CNT_W  = 3;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    logic [1:0]            state_reg, state_next;
    logic [CNT_W-1:0]      cnt_reg, cnt_next;
    logic                  we_reg;
    logic                  err_reg;

    logic                  accept;
    logic [LANE_W-1:0]     req_lane;
    logic [IDX_W-1:0]      req_idx;
    logic                  range_err;
    logic                  req_err;
    logic [WORD_BYTES-1:0] wr_mask;
    logic [DATA_W-1:0]     wr_data_sh;
    logic                  wr_en;
    logic                  rd_en;
    logic [DATA_W-1:0]     rd_word;
    logic [DATA_W-1:0]     load_data;

    assign req_ready = (state_reg == S_IDLE);
    assign accept    = req_valid & req_ready;
    assign req_lane  = req_addr[LANE_W-1:0];
    assign req_idx   = req_addr[LANE_W +: IDX_W];
    // Any address bit above the word index means the byte address is past the array end.
    assign range_err = |(req_addr >> (LANE_W + IDX_W));

`ifdef DMEM_BYTE_LANE_EN
    logic [1:0]        size_reg;
    logic              signed_reg;
    logic [LANE_W-1:0] lane_reg;
    logic [DATA_W-1:0] rd_shift;

    // Classify the request: lane mask for stores and alignment/size errors.
    always_comb begin
        req_err = range_err;
        wr_mask = '1;
        case (req_size)
            SZ_BYTE: wr_mask = WORD_BYTES'(1'b1) << req_lane;
            SZ_HALF: begin
                wr_mask = WORD_BYTES'(2'b11) << req_lane;
                if (req_addr[0]) req_err = 1'b1;
            end
            SZ_WORD: if (req_lane != '0) req_err = 1'b1;
            default: req_err = 1'b1;
        endcase
    end

    // Sub-word store data arrives in the LSBs; move it up to the addressed lanes.
    assign wr_data_sh = req_wdata << {req_lane, 3'b000};

    // Capture the load-formatting fields at acceptance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            size_reg   <= SZ_WORD;
            signed_reg <= 1'b0;
            lane_reg   <= '0;
        end else if (accept) begin
            size_reg   <= req_size;
            signed_reg <= req_signed;
            lane_reg   <= req_lane;
        end
    end

    // Right-justify the selected bytes, then zero- or sign-extend.
    assign rd_shift = rd_word >> {lane_reg, 3'b000};

    // Extend sub-word loads; word loads pass straight through.
    always_comb begin
        load_data = rd_shift;
        case (size_reg)
            SZ_BYTE: load_data = {{(DATA_W-8){signed_reg & rd_shift[7]}}, rd_shift[7:0]};
            SZ_HALF: load_data = {{(DATA_W-16){signed_reg & rd_shift[15]}}, rd_shift[15:0]};
            default: load_data = rd_shift;
        endcase
    end
`else
    logic unused_signed;
    assign unused_signed = req_signed;

    // Word-only port: anything but an aligned, in-range word is an error.
    assign req_err    = range_err | (req_size != SZ_WORD) | (req_lane != '0);
    assign wr_mask    = '1;
    assign wr_data_sh = req_wdata;
    assign load_data  = rd_word;
`endif

    // A store commits on its acceptance edge; nothing is written while rst is high.
    assign wr_en = accept & req_we & ~req_err & ~rst;
    assign rd_en = accept & ~req_we & ~req_err;

    // One byte-wide array per lane so stores touch only the addressed lanes.
    generate
        for (genvar gi = 0; gi < WORD_BYTES; gi++) begin : g_lane
            logic [7:0] mem_lane [DEPTH_WORDS];
            logic [7:0] rd_byte_reg;

            // Lane write on store acceptance, registered read on load acceptance.
            always_ff @(posedge clk) begin
                if (wr_en && wr_mask[gi]) begin
                    mem_lane[req_idx] <= wr_data_sh[gi*8 +: 8];
                end
                if (rd_en) begin
                    rd_byte_reg <= mem_lane[req_idx];
                end
            end

            assign rd_word[gi*8 +: 8] = rd_byte_reg;
        end
    endgenerate

    // Next-state logic: stores and errors go straight to RESP; loads count down.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            S_IDLE: begin
                if (accept) begin
                    if (req_we || req_err || (RD_LAT == 1)) begin
                        state_next = S_RESP;
                    end else begin
                        state_next = S_WAIT;
                        cnt_next   = CNT_W'(RD_LAT - 1);
                    end
                end
            end
            S_WAIT: begin
                cnt_next = cnt_reg - CNT_W'(1);
                if (cnt_reg == CNT_W'(1)) state_next = S_RESP;
            end
            S_RESP: begin
                if (rsp_ready) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // State, countdown and captured request type; rst drops any pending response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= S_IDLE;
            cnt_reg   <= '0;
            we_reg    <= 1'b0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            if (accept) begin
                we_reg  <= req_we;
                err_reg <= req_err;
            end
        end
    end

    // Response outputs are derived from held registers, so they stay stable under backpressure.
    assign rsp_valid = (state_reg == S_RESP);
    assign rsp_err   = rsp_valid & err_reg;
    assign rsp_rdata = (rsp_valid && !err_reg && !we_reg) ? load_data : '0;

endmodule

// File: doc/dmem_port.md
# dmem_port

Parametrised, handshaked data-memory port for the pipelined core's MEM stage. It replaces a fixed 32-bit, zero-latency word memory with a configurable-width, configurable-depth array. The array has a programmable read latency, byte/halfword/word access with sign extension, and alignment/range error reporting. One request is outstanding at a time, and every accepted request produces exactly one response.

## Interface
- WORD_BYTES, 4, bytes per word; power of two, 2..8
- DEPTH_WORDS, 1024, number of words; power of two
- RD_LAT, 2, cycles from read acceptance to rsp_valid; 1..4
- ADDR_W, 32, byte-address width
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  port can accept a request
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 halfword, 10 word, 11 reserved (error)
- req_signed  in  1  sign-extend sub-word loads
- req_addr  in  ADDR_W  byte address
- req_wdata  in  8*WORD_BYTES  store data; sub-word data taken from LSBs
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts response
- rsp_rdata  out  8*WORD_BYTES  load data, right-justified and extended; 0 for stores and errors
- rsp_err  out  1  misaligned, out-of-range or reserved-size access

## Operation
- FSM states:
  - IDLE: req_ready=1.
  - WAIT: latency countdown; entered on read acceptance when RD_LAT>1.
  - RESP: rsp_valid=1, held until rsp_ready.
- Transitions:
  - Acceptance means req_valid & req_ready at a rising edge.
  - Store, error, or read with RD_LAT=1 → RESP.
  - Other reads → WAIT, counter loaded with RD_LAT-1.
  - WAIT → RESP when counter reaches 0.
  - RESP & rsp_ready → IDLE.
- Addressing:
  - Little-endian.
  - Word index = req_addr >> log2(WORD_BYTES).
  - Byte lane = req_addr[log2(WORD_BYTES)-1:0].
- Error conditions; all yield rsp_err=1, rsp_rdata=0, no array write:
  - halfword with addr[0]=1;
  - word with a nonzero lane;
  - req_addr ≥ DEPTH_WORDS*WORD_BYTES;
  - size=11.
- Stores write only the addressed lanes; other bytes are preserved.
- Loads:
  - The selected bytes are shifted to bit 0.
  - Upper bits are zero-filled, or replicated from the top selected bit when req_signed=1.
  - req_signed is ignored for word size.
- Request fields are captured at acceptance. Input changes while not ready are ignored.
- Array contents are not cleared by rst.

## Timing
- Reset values:
  - req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0
  - state IDLE, counter 0
- Store commits to the array on the acceptance edge; rsp_valid rises the next cycle.
- Load: rsp_valid rises exactly RD_LAT cycles after the acceptance edge, with rsp_rdata/rsp_err valid.
- Error responses rise 1 cycle after acceptance regardless of RD_LAT.
- Backpressure:
  - rsp_valid, rsp_rdata and rsp_err hold stable while rsp_ready=0.
  - The response completes on the edge where rsp_valid & rsp_ready.
  - req_ready rises the following cycle; there is no same-cycle turnaround.
  - Steady-state throughput is 1 store per 2 cycles and 1 load per RD_LAT+1 cycles.
- A load immediately after a store to the same address returns the stored data.
- rst asserted mid-operation:
  - Returns to IDLE immediately and drops any pending response.
  - A store already committed stays committed.

## Configuration
- DMEM_BYTE_LANE_EN defined: byte and halfword accesses are supported as above.
- DMEM_BYTE_LANE_EN undefined:
  - Only word accesses are legal; req_size≠10 gives rsp_err=1 with no write.
  - Lane-select and extension logic is removed; req_signed is ignored.

## Test plan
- Word store then load (WORD_BYTES=4, RD_LAT=2):
  - Store 0xDEADBEEF at 0x400 → rsp_valid 1 cycle later, err=0.
  - Load 0x400 → 0xDEADBEEF exactly 2 cycles after acceptance.
- Sub-word access (DMEM_BYTE_LANE_EN):
  - Store byte 0xAB at 0x401; word load 0x400 → 0xDEADABEF.
  - Signed byte load 0x401 → 0xFFFFFFAB; unsigned → 0x000000AB.
  - Signed halfword load 0x402 → 0xFFFFDEAD.
- Errors:
  - Word store at 0x402 → err=1, rdata=0; word at 0x400 unchanged.
  - Load at 0x1000 (DEPTH_WORDS=1024) → err=1 after 1 cycle.
  - Size 11 → err=1.
- Backpressure:
  - Hold rsp_ready=0 for 5 cycles after a load response → rsp_valid/rsp_rdata stable and req_ready=0 throughout.
  - req_ready=1 the cycle after rsp_ready rises.
- Reset:
  - Assert rst during WAIT → rsp_valid=0 and req_ready=1 immediately.
  - No response is delivered after rst release.
  - A subsequent load returns the previously stored data.
- DMEM_BYTE_LANE_EN undefined → byte store to 0x400 gives err=1 and the word is unchanged.
